// File: rtl/dht11_sample_scheduler.sv
// DHT11 read scheduler: periodic and forced reads, bounded retries,
// and publication of the last good humidity/temperature sample.
module dht11_sample_scheduler #(
    parameter int INTERVAL_CYCLES = 300_000_000,
    parameter int MIN_GAP_CYCLES  = 200_000_000,
    parameter int TIMEOUT_CYCLES  = 10_000_000,
    parameter int MAX_RETRY       = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       force_req,
    output logic       rd_start,
    input  logic       rd_busy,
    input  logic       rd_done,
    input  logic [7:0] rd_humidity,
    input  logic [7:0] rd_temperature,
    input  logic       rd_chk_ok,
    output logic [7:0] humidity,
    output logic [7:0] current_temperature,
    output logic       data_valid,
    output logic       stale,
    output logic       update,
    output logic [7:0] err_count
);

    localparam int GAP_W = (INTERVAL_CYCLES > 1) ? $clog2(INTERVAL_CYCLES) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(INTERVAL_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_MIN = GAP_W'(MIN_GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_TMO = GAP_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);
    localparam logic [RTY_W-1:0] RTY_ONE = RTY_W'(1);

    typedef enum logic [1:0] {
        S_WAIT,
        S_START,
        S_WAIT_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic             force_pend_q, force_pend_d;
    logic             rd_start_q, rd_start_d;
    logic [7:0]       hum_q, hum_d;
    logic [7:0]       temp_q, temp_d;
    logic [7:0]       err_q, err_d;
    logic             valid_q, valid_d;
    logic             stale_q, stale_d;
    logic             update_q, update_d;

    logic gap_at_max;
    logic gap_past_min;
    logic gap_tmo;
    logic want_read;
    logic rd_ok;
    logic rd_fail;

    assign gap_at_max   = (gap_q == GAP_MAX);
    assign gap_past_min = (gap_q >= GAP_MIN);
    assign gap_tmo      = (gap_q == GAP_TMO);

    assign want_read = gap_at_max
                    || ((force_pend_q || (retry_q != '0)) && gap_past_min);

    // A completion in the timeout cycle is judged on its checksum alone.
    assign rd_ok   = rd_done && rd_chk_ok;
    assign rd_fail = (rd_done && !rd_chk_ok) || (gap_tmo && !rd_done);

    always_comb begin
        state_d      = state_q;
        gap_d        = gap_at_max ? gap_q : gap_q + GAP_ONE;
        retry_d      = retry_q;
        force_pend_d = force_pend_q | force_req;
        rd_start_d   = 1'b0;
        hum_d        = hum_q;
        temp_d       = temp_q;
        err_d        = err_q;
        valid_d      = valid_q;
        stale_d      = stale_q;
        update_d     = 1'b0;

        unique case (state_q)
            S_WAIT: begin
                if (!rd_busy && want_read) begin
                    state_d      = S_START;
                    gap_d        = '0;
                    rd_start_d   = 1'b1;
                    force_pend_d = force_req;
                end
            end
            S_START: begin
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                unique case (1'b1)
                    rd_ok: begin
                        state_d  = S_WAIT;
                        hum_d    = rd_humidity;
                        temp_d   = rd_temperature;
                        update_d = 1'b1;
                        valid_d  = 1'b1;
                        stale_d  = 1'b0;
                        retry_d  = '0;
                    end
                    rd_fail: begin
                        state_d = S_WAIT;
                        err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
                        if (retry_q < RTY_MAX) begin
                            retry_d = retry_q + RTY_ONE;
                        end else begin
                            retry_d = '0;
                            stale_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_WAIT;
            gap_q        <= '0;
            retry_q      <= '0;
            force_pend_q <= 1'b0;
            rd_start_q   <= 1'b0;
            hum_q        <= 8'd0;
            temp_q       <= 8'd0;
            err_q        <= 8'd0;
            valid_q      <= 1'b0;
            stale_q      <= 1'b0;
            update_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            retry_q      <= retry_d;
            force_pend_q <= force_pend_d;
            rd_start_q   <= rd_start_d;
            hum_q        <= hum_d;
            temp_q       <= temp_d;
            err_q        <= err_d;
            valid_q      <= valid_d;
            stale_q      <= stale_d;
            update_q     <= update_d;
        end
    end

    assign rd_start            = rd_start_q;
    assign humidity            = hum_q;
    assign current_temperature = temp_q;
    assign data_valid          = valid_q;
    assign stale               = stale_q;
    assign update              = update_q;
    assign err_count           = err_q;

    a_start_pulse : assert property (
        @(posedge clk) disable iff (reset) rd_start_q |=> !rd_start_q
    );

    a_start_state : assert property (
        @(posedge clk) disable iff (reset) (state_q == S_START) |-> rd_start_q
    );

endmodule

// File: tb/tb_dht11_sample_scheduler.sv
// Bench for dht11_sample_scheduler: table of read scenarios driven through
// a reader model, with start/update scoreboards and a reset-mid-read sequence.
module tb_dht11_sample_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       force_req;
    logic       rd_start;
    logic       rd_busy;
    logic       rd_done;
    logic [7:0] rd_humidity;
    logic [7:0] rd_temperature;
    logic       rd_chk_ok;
    logic [7:0] humidity;
    logic [7:0] current_temperature;
    logic       data_valid;
    logic       stale;
    logic       update;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    dht11_sample_scheduler #(
        .INTERVAL_CYCLES(100),
        .MIN_GAP_CYCLES (40),
        .TIMEOUT_CYCLES (20),
        .MAX_RETRY      (2)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .force_req          (force_req),
        .rd_start           (rd_start),
        .rd_busy            (rd_busy),
        .rd_done            (rd_done),
        .rd_humidity        (rd_humidity),
        .rd_temperature     (rd_temperature),
        .rd_chk_ok          (rd_chk_ok),
        .humidity           (humidity),
        .current_temperature(current_temperature),
        .data_valid         (data_valid),
        .stale              (stale),
        .update             (update),
        .err_count          (err_count)
    );

    typedef struct {
        int         ncyc;
        int         dly;
        logic [7:0] ans;
        logic [7:0] ok;
        logic [7:0] hum;
        logic [7:0] tmp;
        int         f0;
        int         f1;
        int         busy_lo;
        int         busy_hi;
        int         stray;
        int         st0;
        int         st1;
        int         st2;
        int         st3;
        int         st4;
        int         e_err;
        logic       e_stale;
        logic       e_valid;
        logic [7:0] e_hum;
        logic [7:0] e_tmp;
    } vec_t;

    typedef struct packed {
        int         cyc;
        logic [7:0] hum;
        logic [7:0] tmp;
    } upd_t;

    int   n_pass = 0;
    int   n_tot  = 0;
    int   start_q[$];
    upd_t upd_q[$];
    vec_t tbl[6];
    vec_t v6a;
    vec_t v6b;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_start"}, int'(rd_start), 0);
        chk({tag, "_update"}, int'(update), 0);
        chk({tag, "_valid"}, int'(data_valid), 0);
        chk({tag, "_stale"}, int'(stale), 0);
        chk({tag, "_err"}, int'(err_count), 0);
        chk({tag, "_hum"}, int'(humidity), 0);
        chk({tag, "_tmp"}, int'(current_temperature), 0);
    endtask

    function automatic vec_t mk(
        input int ncyc, input int dly,
        input logic [7:0] ans, input logic [7:0] ok,
        input logic [7:0] hum, input logic [7:0] tmp,
        input int f0, input int f1,
        input int blo, input int bhi, input int stray,
        input int s0, input int s1, input int s2,
        input int s3, input int s4,
        input int e_err, input logic e_stale, input logic e_valid,
        input logic [7:0] e_hum, input logic [7:0] e_tmp
    );
        vec_t v;
        v.ncyc = ncyc;   v.dly = dly;
        v.ans = ans;     v.ok = ok;
        v.hum = hum;     v.tmp = tmp;
        v.f0 = f0;       v.f1 = f1;
        v.busy_lo = blo; v.busy_hi = bhi;
        v.stray = stray;
        v.st0 = s0; v.st1 = s1; v.st2 = s2;
        v.st3 = s3; v.st4 = s4;
        v.e_err = e_err;
        v.e_stale = e_stale;
        v.e_valid = e_valid;
        v.e_hum = e_hum;
        v.e_tmp = e_tmp;
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        force_req = 1'b0;
        rd_busy = 1'b0;
        rd_done = 1'b0;
        rd_chk_ok = 1'b0;
        rd_humidity = 8'd0;
        rd_temperature = 8'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Entered 1 time unit after the edge that opens cycle 0; the loop
    // variable c is the cycle number counted from reset release.
    task automatic run(input vec_t v, input bit fin);
        int   att = 0;
        int   done_at = -1;
        logic done_ok = 1'b0;
        upd_t u;
        start_q.delete();
        upd_q.delete();
        if (v.st0 >= 0) start_q.push_back(v.st0);
        if (v.st1 >= 0) start_q.push_back(v.st1);
        if (v.st2 >= 0) start_q.push_back(v.st2);
        if (v.st3 >= 0) start_q.push_back(v.st3);
        if (v.st4 >= 0) start_q.push_back(v.st4);
        for (int c = 0; c < v.ncyc; c++) begin
            force_req = (c == v.f0) || (c == v.f1);
            rd_busy = (c >= v.busy_lo) && (c <= v.busy_hi);
            rd_done = 1'b0;
            rd_chk_ok = 1'b0;
            rd_humidity = 8'd0;
            rd_temperature = 8'd0;
            if (c == done_at) begin
                rd_done = 1'b1;
                rd_chk_ok = done_ok;
                rd_humidity = done_ok ? v.hum : ~v.hum;
                rd_temperature = done_ok ? v.tmp : ~v.tmp;
                if (done_ok) begin
                    u.cyc = c + 1;
                    u.hum = v.hum;
                    u.tmp = v.tmp;
                    upd_q.push_back(u);
                end
            end else if (c == v.stray) begin
                rd_done = 1'b1;
                rd_chk_ok = 1'b1;
                rd_humidity = 8'h55;
                rd_temperature = 8'h66;
            end

            @(negedge clk);
            if (c == 0) check_zero("reset");
            if (rd_start) begin
                if (start_q.size() == 0) chk("rd_start_unexpected", c, -1);
                else chk("rd_start_cycle", c, start_q.pop_front());
                if (att < 8 && v.ans[att[2:0]]) begin
                    done_at = c + v.dly;
                    done_ok = v.ok[att[2:0]];
                end else begin
                    done_at = -1;
                end
                att++;
            end
            if (update) begin
                if (upd_q.size() == 0) begin
                    chk("update_unexpected", c, -1);
                end else begin
                    u = upd_q.pop_front();
                    chk("update_cycle", c, u.cyc);
                    chk("humidity", int'(humidity), int'(u.hum));
                    chk("temperature", int'(current_temperature), int'(u.tmp));
                end
            end
            if (fin && c == v.ncyc - 1) begin
                chk("starts_missing", start_q.size(), 0);
                chk("updates_missing", upd_q.size(), 0);
                chk("err_count", int'(err_count), v.e_err);
                chk("stale", int'(stale), int'(v.e_stale));
                chk("data_valid", int'(data_valid), int'(v.e_valid));
                chk("final_hum", int'(humidity), int'(v.e_hum));
                chk("final_tmp", int'(current_temperature), int'(v.e_tmp));
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // periodic reads, plus a stray rd_done while idle
        tbl[0] = mk(210, 5, 8'hFF, 8'hFF, 8'h3C, 8'h1C, -1, -1, -1, -1, 50,
                    100, 200, -1, -1, -1, 0, 1'b0, 1'b1, 8'h3C, 8'h1C);
        // forced read; second force while one is already pending
        tbl[1] = mk(250, 5, 8'hFF, 8'hFF, 8'h41, 8'h17, 105, 110, -1, -1, -1,
                    100, 140, 240, -1, -1, 0, 1'b0, 1'b1, 8'h41, 8'h17);
        // checksum failure then successful retry
        tbl[2] = mk(250, 5, 8'hFF, 8'hFE, 8'h40, 8'h19, -1, -1, -1, -1, -1,
                    100, 140, 240, -1, -1, 1, 1'b0, 1'b1, 8'h40, 8'h19);
        // reader never answers: retries exhausted
        tbl[3] = mk(295, 5, 8'h00, 8'h00, 8'h00, 8'h00, -1, -1, -1, -1, -1,
                    100, 140, 180, 280, -1, 3, 1'b1, 1'b0, 8'h00, 8'h00);
        // one good read, then exhaustion must hold that data
        tbl[4] = mk(390, 5, 8'h01, 8'h01, 8'h22, 8'h15, -1, -1, -1, -1, -1,
                    100, 200, 240, 280, 380, 3, 1'b1, 1'b1, 8'h22, 8'h15);
        // busy as seen by the edges opening cycles 95..110,
        // then rd_done lands on the timeout cycle
        tbl[5] = mk(220, 19, 8'hFF, 8'hFF, 8'h2A, 8'h1B, -1, -1, 94, 109, -1,
                    111, 211, -1, -1, -1, 0, 1'b0, 1'b1, 8'h2A, 8'h1B);

        v6a = mk(103, 5, 8'h00, 8'h00, 8'h00, 8'h00, -1, -1, -1, -1, -1,
                 100, -1, -1, -1, -1, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        v6b = mk(110, 5, 8'h00, 8'h00, 8'h00, 8'h00, -1, -1, -1, -1, 2,
                 100, -1, -1, -1, -1, 0, 1'b0, 1'b0, 8'h00, 8'h00);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            run(tbl[i], 1'b1);
        end

        // reset three cycles after rd_start, rd_done afterwards is ignored
        do_reset();
        run(v6a, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_zero("midreset");
        @(posedge clk);
        #1 reset = 1'b0;
        run(v6b, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
